// File: rtl/divider_iter.sv
// divider_iter: multi-cycle restoring integer divider (signed/unsigned) with valid/ack handshake and annul.
// Optional feature macro: DIVIDER_ITER_EARLY_OUT_EN bypasses CALC when |dividend| < |divisor|.
module divider_iter #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);
    localparam int N  = WIDTH / STEPS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_quo;
    logic             a_neg, b_neg, accept, skip, last, zero_div;

    assign a_neg    = signed_i && dividend_i[WIDTH-1];
    assign b_neg    = signed_i && divisor_i[WIDTH-1];
    assign a_mag    = a_neg ? -dividend_i : dividend_i;
    assign b_mag    = b_neg ? -divisor_i : divisor_i;
    assign accept   = start_i && !annul_i;
    assign zero_div = divisor_i == '0;
    assign last     = cnt_q == CW'(N - 1);

`ifdef DIVIDER_ITER_EARLY_OUT_EN
    assign skip = a_mag < b_mag;
`else
    assign skip = 1'b0;
`endif

    // Chained restoring steps: shift next dividend bit into the partial remainder, keep the trial if no borrow
    always_comb begin
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        step_rem = rem_q;
        step_quo = quo_q;
        trial    = '0;
        diff     = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            trial    = {step_rem, step_quo[WIDTH-1]};
            diff     = trial - {1'b0, dvs_q};
            step_quo = {step_quo[WIDTH-2:0], ~diff[WIDTH]};
            step_rem = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; annul returns to IDLE from any busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = zero_div ? DONE : skip ? FIX : CALC;
            CALC:    state_d = annul_i ? IDLE : last ? FIX : CALC;
            FIX:     state_d = annul_i ? IDLE : DONE;
            DONE:    state_d = (annul_i || ack_i) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_o      = state_q != IDLE;
        valid_o     = state_q == DONE;
        quotient_o  = quotient_q;
        remainder_o = remainder_q;
        div_zero_o  = div_zero_q;
    end

    // Datapath next values: operand capture, iteration, sign fix-up and result capture
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            IDLE: if (accept) begin
                cnt_d     = '0;
                dvs_d     = b_mag;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                rem_d     = skip ? a_mag : '0;
                quo_d     = skip ? '0 : a_mag;
                if (zero_div) begin
                    quotient_d  = '1;
                    remainder_d = dividend_i;
                    div_zero_d  = 1'b1;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                rem_d = step_rem;
                quo_d = step_quo;
            end
            FIX: if (!annul_i) begin
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                div_zero_d  = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end
endmodule

// File: tb/tb_divider_iter.sv
// tb_divider_iter: randomized self-checking bench for divider_iter (32x1 and 16x2 instances).
module tb_divider_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

`ifdef DIVIDER_ITER_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        a_start, a_signed, a_annul, a_ack, a_busy, a_valid, a_dz;
    logic [31:0] a_dvd, a_dvs, a_quo, a_rem;
    logic        b_start, b_signed, b_annul, b_ack, b_busy, b_valid, b_dz;
    logic [15:0] b_dvd, b_dvs, b_quo, b_rem;

    divider_iter #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .signed_i(a_signed), .annul_i(a_annul),
        .dividend_i(a_dvd), .divisor_i(a_dvs), .ack_i(a_ack), .busy_o(a_busy), .valid_o(a_valid),
        .quotient_o(a_quo), .remainder_o(a_rem), .div_zero_o(a_dz)
    );

    divider_iter #(.WIDTH(16), .STEPS_PER_CYCLE(2)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .signed_i(b_signed), .annul_i(b_annul),
        .dividend_i(b_dvd), .divisor_i(b_dvs), .ack_i(b_ack), .busy_o(b_busy), .valid_o(b_valid),
        .quotient_o(b_quo), .remainder_o(b_rem), .div_zero_o(b_dz)
    );

    // Reference: 64-bit integer division (truncating) on the sign-interpreted operands
    function automatic void ref_div(input bit sgn, input int w, input int steps,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, m;
        m  = longint'(1) << w;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa -= m;
        if (sgn && b[w-1]) sb -= m;
        if (sb == 0) begin
            q   = 32'(m - 1);
            r   = a;
            lat = 1;
        end else begin
            q   = 32'((sa / sb) & (m - 1));
            r   = 32'((sa % sb) & (m - 1));
            lat = (EARLY && ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb))) ? 2 : w / steps + 2;
        end
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h1 << (w - 1);
            4:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return (w == 32) ? v : (v & 32'h0000_FFFF);
    endfunction

    task automatic run_a(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
        logic [31:0] eq, er;
        int lat, edges;
        ref_div(sgn, 32, 1, a, b, eq, er, lat);
        a_start = 1'b1; a_signed = sgn; a_dvd = a; a_dvs = b;
        edges = 0;
        do begin
            @(posedge clk); #1; edges++;
            a_start = 1'($urandom_range(0, 1)); a_signed = 1'($urandom_range(0, 1));
            a_dvd = $urandom; a_dvs = $urandom;
        end while (!a_valid && edges < 100);
        checks++;
        if (edges != lat) begin failures++; $display("FAIL %s latency got=%0d want=%0d", tag, edges, lat); end
        checks++;
        if (a_quo !== eq) begin failures++; $display("FAIL %s quotient got=%h want=%h", tag, a_quo, eq); end
        checks++;
        if (a_rem !== er) begin failures++; $display("FAIL %s remainder got=%h want=%h", tag, a_rem, er); end
        checks++;
        if (a_dz !== (b == 32'h0)) begin failures++; $display("FAIL %s div_zero got=%b want=%b", tag, a_dz, b == 32'h0); end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            a_start = 1'($urandom_range(0, 1)); a_dvd = $urandom; a_dvs = $urandom;
            checks++;
            if (!a_valid || a_quo !== eq || a_rem !== er)
                begin failures++; $display("FAIL %s hold%0d valid=%b q=%h r=%h want q=%h r=%h", tag, i, a_valid, a_quo, a_rem, eq, er); end
        end
        a_ack = 1'b1; a_start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        a_ack = 1'b0; a_start = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0)
            begin failures++; $display("FAIL %s after_ack valid=%b busy=%b want 0 0", tag, a_valid, a_busy); end
    endtask

    task automatic run_b(input bit sgn, input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [31:0] eq, er;
        int lat, edges;
        ref_div(sgn, 16, 2, {16'h0, a}, {16'h0, b}, eq, er, lat);
        b_start = 1'b1; b_signed = sgn; b_dvd = a; b_dvs = b;
        edges = 0;
        do begin
            @(posedge clk); #1; edges++;
            b_start = 1'b0; b_dvd = 16'($urandom); b_dvs = 16'($urandom);
        end while (!b_valid && edges < 100);
        checks++;
        if (edges != lat) begin failures++; $display("FAIL %s latency got=%0d want=%0d", tag, edges, lat); end
        checks++;
        if ({b_quo, b_rem, b_dz} !== {eq[15:0], er[15:0], b == 16'h0})
            begin failures++; $display("FAIL %s result got q=%h r=%h dz=%b want q=%h r=%h dz=%b", tag, b_quo, b_rem, b_dz, eq[15:0], er[15:0], b == 16'h0); end
        b_ack = 1'b1;
        @(posedge clk); #1;
        b_ack = 1'b0;
        checks++;
        if (b_valid !== 1'b0 || b_busy !== 1'b0)
            begin failures++; $display("FAIL %s after_ack valid=%b busy=%b want 0 0", tag, b_valid, b_busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_start = 0; a_signed = 0; a_annul = 0; a_ack = 0; a_dvd = '0; a_dvs = '0;
        b_start = 0; b_signed = 0; b_annul = 0; b_ack = 0; b_dvd = '0; b_dvs = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_valid, a_dz, a_quo, a_rem} !== '0)
            begin failures++; $display("FAIL reset_a busy=%b valid=%b dz=%b q=%h r=%h want all 0", a_busy, a_valid, a_dz, a_quo, a_rem); end
        checks++;
        if ({b_busy, b_valid, b_dz, b_quo, b_rem} !== '0)
            begin failures++; $display("FAIL reset_b busy=%b valid=%b dz=%b q=%h r=%h want all 0", b_busy, b_valid, b_dz, b_quo, b_rem); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_a(1'b0, 32'd100, 32'd7, 5, "u100_7");
        run_a(1'b1, 32'hFFFF_FFF9, 32'd2, 1, "s-7_2");
        run_a(1'b1, 32'd7, 32'hFFFF_FFFE, 1, "s7_-2");
        run_a(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "smin_-1");
        run_a(1'b0, 32'h1234, 32'h0, 2, "u_div0");
        run_a(1'b1, 32'hFFFF_FF00, 32'h0, 0, "s_div0");
        run_a(1'b0, 32'd3, 32'd10, 0, "u3_10");
        run_a(1'b1, 32'hFFFF_FFFD, 32'd10, 0, "s-3_10");
    endtask

    task automatic test_annul_calc();
        a_start = 1'b1; a_signed = 1'b0; a_dvd = 32'd1000; a_dvs = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            a_start = 1'b0;
            checks++;
            if (a_valid !== 1'b0 || a_busy !== 1'b1)
                begin failures++; $display("FAIL annul_calc pre%0d valid=%b busy=%b want 0 1", i, a_valid, a_busy); end
        end
        a_annul = 1'b1;
        @(posedge clk); #1;
        a_annul = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0)
            begin failures++; $display("FAIL annul_calc post valid=%b busy=%b want 0 0", a_valid, a_busy); end
        run_a(1'b0, 32'hFFFF_FFFF, 32'h10, 0, "after_annul");
    endtask

    task automatic test_annul_fix();
        a_start = 1'b1; a_signed = 1'b0; a_dvd = 32'd1000; a_dvs = 32'd3;
        repeat (33) begin
            @(posedge clk); #1;
            a_start = 1'b0;
        end
        a_annul = 1'b1;
        @(posedge clk); #1;
        a_annul = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0)
            begin failures++; $display("FAIL annul_fix valid=%b busy=%b want 0 0", a_valid, a_busy); end
        @(posedge clk); #1;
        checks++;
        if (a_valid !== 1'b0) begin failures++; $display("FAIL annul_fix late_valid got=%b want 0", a_valid); end
    endtask

    task automatic test_annul_done_idle();
        a_start = 1'b1; a_dvd = 32'd5; a_dvs = 32'd0;
        @(posedge clk); #1;
        a_start = 1'b0;
        checks++;
        if (a_valid !== 1'b1) begin failures++; $display("FAIL annul_done pre valid=%b want 1", a_valid); end
        a_annul = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0)
            begin failures++; $display("FAIL annul_done valid=%b busy=%b want 0 0", a_valid, a_busy); end
        a_start = 1'b1; a_dvd = 32'd9; a_dvs = 32'd3;
        @(posedge clk); #1;
        a_start = 1'b0; a_annul = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0)
            begin failures++; $display("FAIL annul_idle busy=%b valid=%b want 0 0", a_busy, a_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_a(1'($urandom_range(0, 1)), pick(32), pick(32), $urandom_range(0, 2), $sformatf("rnd%0d", i));
    endtask

    task automatic test_w16();
        run_b(1'b0, 16'hFFFF, 16'd3, "w16_ffff_3");
        for (int i = 0; i < 20; i++)
            run_b(1'($urandom_range(0, 1)), 16'(pick(16)), 16'(pick(16)), $sformatf("w16rnd%0d", i));
        b_start = 1'b1; b_signed = 1'b0; b_dvd = 16'hFFFF; b_dvs = 16'd7;
        repeat (3) begin
            @(posedge clk); #1;
            b_start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({b_busy, b_valid, b_dz, b_quo, b_rem} !== '0)
            begin failures++; $display("FAIL w16_rst busy=%b valid=%b dz=%b q=%h r=%h want all 0", b_busy, b_valid, b_dz, b_quo, b_rem); end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (b_valid !== 1'b0) begin failures++; $display("FAIL w16_rst late_valid got=%b want 0", b_valid); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_annul_calc();
        test_annul_fix();
        test_annul_done_idle();
        test_random();
        test_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
